// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM encodings for the sequential execute ALU.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD     = 4'd0,
    OP_LT      = 4'd1,
    OP_LTU     = 4'd2,
    OP_AND     = 4'd3,
    OP_OR      = 4'd4,
    OP_XOR     = 4'd5,
    OP_SLL     = 4'd6,
    OP_SRL     = 4'd7,
    OP_SUB     = 4'd8,
    OP_SRA     = 4'd9,
    OP_EQ      = 4'd10,
    OP_NE      = 4'd11,
    OP_GE      = 4'd12,
    OP_GEU     = 4'd13,
    OP_MUL     = 4'd14,
    OP_ILLEGAL = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_shift(input alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_shift_step.sv
// One iteration of the iterative shifter: shifts value by 0..SHIFT_STEP bits.
module alu_seq_shift_step #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic [XLEN-1:0]                   value,
  input  logic                              right,
  input  logic                              arith,
  input  logic [$clog2(SHIFT_STEP+1)-1:0]   amount,
  output logic [XLEN-1:0]                   shifted
);

  localparam int AW = $clog2(SHIFT_STEP + 1);

  logic [XLEN-1:0] cand [SHIFT_STEP+1];

  // Arithmetic shift is kept in its own expression so signedness is not lost to a mixed ternary.
  generate
    for (genvar gi = 0; gi <= SHIFT_STEP; gi++) begin : g_cand
      logic [XLEN-1:0] sra_val;
      assign sra_val   = $unsigned($signed(value) >>> gi);
      assign cand[gi]  = right ? (arith ? sra_val : (value >> gi)) : (value << gi);
    end
  endgenerate

  always_comb begin
    shifted = value;
    for (int k = 0; k <= SHIFT_STEP; k++) begin
      if (amount == AW'(k)) shifted = cand[k];
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute ALU: single-cycle arith/logic/compare, iterative shifts and shift-add MUL.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            cond,
  output logic            illegal
);

  localparam int SW = $clog2(XLEN);
  localparam int AW = $clog2(SHIFT_STEP + 1);
  localparam logic [SW-1:0] STEP     = SW'(SHIFT_STEP);
  localparam logic [SW-1:0] LAST_CNT = SW'(XLEN - 1);

  state_e          state_reg;
  alu_op_e         op_reg;
  logic [XLEN-1:0] work_reg;
  logic [XLEN-1:0] mult_reg;
  logic [XLEN-1:0] acc_reg;
  logic [XLEN-1:0] res_reg;
  logic [SW-1:0]   remaining_reg;
  logic [SW-1:0]   count_reg;
  logic            cond_reg;
  logic            illegal_reg;

  alu_op_e         op_in;
  logic            accept;
  logic [XLEN-1:0] single_res;
  logic            single_cond;
  logic [AW-1:0]   step_amt;
  logic [SW-1:0]   remaining_next;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] acc_next;

  assign op_in     = alu_op_e'(alu_op);
  assign in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == ST_DONE);
  assign res       = res_reg;
  assign cond      = cond_reg;
  assign illegal   = illegal_reg;

  always_comb begin
    single_res  = '0;
    single_cond = 1'b0;
    case (op_in)
      OP_ADD: single_res  = a + b;
      OP_SUB: single_res  = a - b;
      OP_AND: single_res  = a & b;
      OP_OR:  single_res  = a | b;
      OP_XOR: single_res  = a ^ b;
      OP_LT:  single_cond = $signed(a) < $signed(b);
      OP_LTU: single_cond = a < b;
      OP_GE:  single_cond = $signed(a) >= $signed(b);
      OP_GEU: single_cond = a >= b;
      OP_EQ:  single_cond = (a == b);
      OP_NE:  single_cond = (a != b);
      default: ;
    endcase
  end

  // The final iteration may be shorter than SHIFT_STEP.
  assign step_amt       = (remaining_reg < STEP) ? AW'(remaining_reg) : AW'(SHIFT_STEP);
  assign remaining_next = remaining_reg - SW'(step_amt);
  assign acc_next       = mult_reg[0] ? (acc_reg + work_reg) : acc_reg;

  alu_seq_shift_step #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shift_step (
    .value   (work_reg),
    .right   (op_reg != OP_SLL),
    .arith   (op_reg == OP_SRA),
    .amount  (step_amt),
    .shifted (shifted)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_ADD;
      work_reg      <= '0;
      mult_reg      <= '0;
      acc_reg       <= '0;
      res_reg       <= '0;
      remaining_reg <= '0;
      count_reg     <= '0;
      cond_reg      <= 1'b0;
      illegal_reg   <= 1'b0;
    end else if (accept) begin
      op_reg        <= op_in;
      work_reg      <= a;
      mult_reg      <= b;
      acc_reg       <= '0;
      count_reg     <= '0;
      remaining_reg <= b[SW-1:0];
      cond_reg      <= 1'b0;
      illegal_reg   <= 1'b0;
      if (is_shift(op_in)) begin
        if (b[SW-1:0] == '0) begin
          res_reg   <= a;
          state_reg <= ST_DONE;
        end else begin
          state_reg <= ST_BUSY;
        end
      end else if (op_in == OP_MUL) begin
        state_reg <= ST_BUSY;
      end else begin
        res_reg     <= single_res;
        cond_reg    <= single_cond;
        illegal_reg <= (op_in == OP_ILLEGAL);
        state_reg   <= ST_DONE;
      end
    end else begin
      case (state_reg)
        ST_BUSY: begin
          if (op_reg == OP_MUL) begin
            acc_reg   <= acc_next;
            work_reg  <= work_reg << 1;
            mult_reg  <= mult_reg >> 1;
            count_reg <= count_reg + 1'b1;
            if (count_reg == LAST_CNT) begin
              res_reg   <= acc_next;
              state_reg <= ST_DONE;
            end
          end else begin
            work_reg      <= shifted;
            remaining_reg <= remaining_next;
            if (remaining_next == '0) begin
              res_reg   <= shifted;
              state_reg <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) state_reg <= ST_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench: two alu_seq instances (SHIFT_STEP 1 and 4) share stimulus against a reference model.
module tb_alu_seq;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [3:0]  alu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_ready;

  logic        in_ready1, out_valid1, cond1, illegal1;
  logic [31:0] res1;
  logic        in_ready4, out_valid4, cond4, illegal4;
  logic [31:0] res4;

  int n_checks = 0;
  int n_fails  = 0;

  alu_seq #(.XLEN(32), .SHIFT_STEP(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .alu_op(alu_op), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
    .res(res1), .cond(cond1), .illegal(illegal1)
  );

  alu_seq #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
    .alu_op(alu_op), .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready),
    .res(res4), .cond(cond4), .illegal(illegal4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic c, output logic il);
    int sh;
    logic [63:0] p;
    sh = int'(y[4:0]);
    r = '0; c = 1'b0; il = 1'b0;
    case (op)
      0:  r = x + y;
      1:  c = $signed(x) < $signed(y);
      2:  c = x < y;
      3:  r = x & y;
      4:  r = x | y;
      5:  r = x ^ y;
      6:  r = x << sh;
      7:  r = x >> sh;
      8:  r = x - y;
      9:  r = $unsigned($signed(x) >>> sh);
      10: c = (x == y);
      11: c = (x != y);
      12: c = $signed(x) >= $signed(y);
      13: c = x >= y;
      14: begin p = 64'(x) * 64'(y); r = p[31:0]; end
      default: il = 1'b1;
    endcase
  endfunction

  function automatic int latency(input int op, input logic [31:0] y, input int step);
    int sh;
    sh = int'(y[4:0]);
    if (op == 6 || op == 7 || op == 9) return (sh == 0) ? 1 : 1 + (sh + step - 1) / step;
    if (op == 14) return 33;
    return 1;
  endfunction

  // Offer one op with out_ready high, collect both results, end one cycle after the last one is taken.
  task automatic do_op(input int op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] er, r1, r4;
    logic ec, ei, c1, c4, i1, i4;
    int l1, l4;
    bit g1, g4;
    g1 = 0; g4 = 0; l1 = 0; l4 = 0;
    r1 = '0; r4 = '0; c1 = 0; c4 = 0; i1 = 0; i4 = 0;
    model(op, x, y, er, ec, ei);
    alu_op = op[3:0]; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    check($sformatf("in_ready1 op%0d", op), in_ready1, 1);
    check($sformatf("in_ready4 op%0d", op), in_ready4, 1);
    @(negedge clock);
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 100 && !(g1 && g4); cyc++) begin
      if (out_valid1 && !g1) begin g1 = 1; l1 = cyc; r1 = res1; c1 = cond1; i1 = illegal1; end
      if (out_valid4 && !g4) begin g4 = 1; l4 = cyc; r4 = res4; c4 = cond4; i4 = illegal4; end
      if (!(g1 && g4)) @(negedge clock);
    end
    check($sformatf("done1 op%0d", op), g1, 1);
    check($sformatf("done4 op%0d", op), g4, 1);
    check($sformatf("lat1 op%0d", op), l1, latency(op, y, 1));
    check($sformatf("lat4 op%0d", op), l4, latency(op, y, 4));
    check($sformatf("res1 op%0d", op), r1, er);
    check($sformatf("res4 op%0d", op), r4, er);
    check($sformatf("cond1 op%0d", op), c1, ec);
    check($sformatf("cond4 op%0d", op), c4, ec);
    check($sformatf("ill1 op%0d", op), i1, ei);
    check($sformatf("ill4 op%0d", op), i4, ei);
    $display("op=%0d a=%h b=%h res=%h cond=%0d ill=%0d lat1=%0d lat4=%0d", op, x, y, r1, c1, i1, l1, l4);
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] er;
    logic ec, ei;
    int ov_seen;

    reset_n = 1'b0; in_valid = 1'b0; alu_op = 4'd0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    check("rst ov1", out_valid1, 0);
    check("rst res1", res1, 0);
    check("rst cond1", cond1, 0);
    check("rst ill1", illegal1, 0);
    check("rst ir1", in_ready1, 1);
    check("rst ov4", out_valid4, 0);

    // MUL interrupted by a two-cycle reset must never deliver.
    alu_op = 4'd14; a = 32'd5; b = 32'd3; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    check("abort ov1", out_valid1, 0);
    check("abort res1", res1, 0);
    check("abort cond1", cond1, 0);
    check("abort ir1", in_ready1, 1);
    check("abort ir4", in_ready4, 1);
    ov_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (out_valid1 || out_valid4) ov_seen++;
    end
    check("abort no result", ov_seen, 0);
    $display("reset mid-MUL: spurious results=%0d", ov_seen);

    do_op(0,  32'hFFFF_FFFF, 32'h0000_0001);
    do_op(1,  32'h8000_0000, 32'h0000_0001);
    do_op(2,  32'h8000_0000, 32'h0000_0001);
    do_op(9,  32'h8000_0000, 32'h0000_0104);
    do_op(6,  32'h1234_5678, 32'h0000_0020);
    do_op(14, 32'h0000_0007, 32'hFFFF_FFFF);
    do_op(7,  32'hF000_000F, 32'h0000_001F);
    do_op(15, 32'hDEAD_BEEF, 32'h1234_5678);

    // Back-to-back single-cycle ops with out_ready high.
    out_ready = 1'b1;
    alu_op = 4'd0; a = 32'h0000_1111; b = 32'h0000_2222; in_valid = 1'b1;
    check("b2b ir1 add", in_ready1, 1);
    @(negedge clock);
    model(0, 32'h0000_1111, 32'h0000_2222, er, ec, ei);
    check("b2b ov1 add", out_valid1, 1);
    check("b2b res1 add", res1, er);
    check("b2b ir1 xor", in_ready1, 1);
    check("b2b ir4 xor", in_ready4, 1);
    alu_op = 4'd5; a = 32'hAAAA_5555; b = 32'h0F0F_0F0F;
    @(negedge clock);
    model(5, 32'hAAAA_5555, 32'h0F0F_0F0F, er, ec, ei);
    check("b2b ov1 xor", out_valid1, 1);
    check("b2b res4 xor", res4, er);
    check("b2b ir1 eq", in_ready1, 1);
    alu_op = 4'd10; a = 32'h0BAD_CAFE; b = 32'h0BAD_CAFE;
    @(negedge clock);
    in_valid = 1'b0;
    check("b2b ov1 eq", out_valid1, 1);
    check("b2b cond1 eq", cond1, 1);
    check("b2b res1 eq", res1, 0);
    @(negedge clock);
    check("b2b ov1 idle", out_valid1, 0);
    $display("back-to-back ADD/XOR/EQ done");

    // Backpressure: result must hold while a competing offer is ignored.
    alu_op = 4'd4; a = 32'h1200_0034; b = 32'h0056_0000; in_valid = 1'b1; out_ready = 1'b0;
    model(4, 32'h1200_0034, 32'h0056_0000, er, ec, ei);
    @(negedge clock);
    alu_op = 4'd0; a = 32'h1; b = 32'h2;
    for (int i = 0; i < 5; i++) begin
      check("bp ov1", out_valid1, 1);
      check("bp res1", res1, er);
      check("bp cond1", cond1, 0);
      check("bp ir1", in_ready1, 0);
      check("bp res4", res4, er);
      @(negedge clock);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp ov1 final", out_valid1, 1);
    check("bp res1 final", res1, er);
    @(negedge clock);
    check("bp ov1 released", out_valid1, 0);
    @(negedge clock);
    check("bp ignored offer", out_valid1, 0);
    $display("backpressure: held res=%h", er);

    for (int i = 0; i < 30; i++) begin
      int op;
      logic [31:0] x, y;
      op = int'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      do_op(op, x, y);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle execute ALU.
- Takes one operation at a time over valid/ready.
- Add/sub, logic and compare ops complete in 1 cycle.
- Shifts run iteratively, SHIFT_STEP bits per cycle; MUL (low XLEN bits) runs iteratively as shift-add, one bit per cycle.
- Sits in the execute stage; lets the core stall on multi-cycle ops instead of using a wide combinational barrel shifter or multiplier.

Parameters:
- XLEN, 32, operand/result width; power of 2, >= 8.
- SHIFT_STEP, 1, bits shifted per iteration; power of 2, 1..XLEN/2.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept an operation this cycle.
- alu_op  in  4  opcode from shared package.
- a  in  XLEN  operand A.
- b  in  XLEN  operand B.
- out_valid  out  1  res/cond/illegal valid.
- out_ready  in  1  consumer takes result.
- res  out  XLEN  arithmetic/logic/shift/mul result; 0 for compare ops.
- cond  out  1  compare result; 0 for non-compare ops.
- illegal  out  1  opcode was unassigned.

Behaviour:
- Reset and clock:
  - Single clock, clock. Reset synchronous, active-low on reset_n.
  - While reset_n=0 at a rising edge: state<=IDLE, out_valid<=0, res<=0, cond<=0, illegal<=0, iteration counters<=0.
  - Reset mid-operation aborts the op; no result is produced.
- FSM states IDLE, BUSY, DONE:
  - in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational, so a new op can be accepted in the same cycle a result is taken.
  - Accept = in_valid & in_ready. On accept, a, b and alu_op are latched.
  - Single-cycle op: next state is DONE, and the result is registered at that edge (latency 1).
  - Shift op: shamt = b[log2(XLEN)-1:0]; upper bits of b are ignored. Working register <= a, remaining <= shamt.
    - If shamt==0: go straight to DONE with res=a.
    - Otherwise go to BUSY.
    - Each BUSY cycle shifts by min(SHIFT_STEP, remaining) and decrements remaining by the same amount.
    - Leave for DONE when remaining reaches 0. Total latency = 1 + ceil(shamt/SHIFT_STEP).
  - MUL: fixed XLEN BUSY cycles. Each cycle: if the multiplier LSB is set, acc += multiplicand. Then multiplicand <<= 1 and multiplier >>= 1.
    - Total latency = XLEN+1, independent of operand values.
    - res = low XLEN bits of a*b; overflow is discarded.
  - DONE: out_valid=1, and res/cond/illegal are held stable until out_ready.
    - out_ready=1 with no accept: go to IDLE, out_valid<=0.
    - out_ready=1 with accept: go to the new op's next state.
  - In BUSY, in_ready=0; in_valid is ignored.
  - out_ready asserted outside DONE has no effect.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN.
  - SRA replicates a[XLEN-1].
  - LT/GE signed; LTU/GEU unsigned.
  - EQ, NE, LT, LTU, GE, GEU set cond, with res=0.
  - All other ops set res, with cond=0.
- Illegal opcode (4'hF): latency 1; res=0, cond=0, illegal=1. illegal is 0 for every legal op.

Decomposition:
- Shared package/header (extends the existing codes header): 4-bit opcodes ADD=0, LT=1, LTU=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, SUB=8, SRA=9, EQ=10, NE=11, GE=12, GEU=13, MUL=14; 15 is reserved/illegal.
- Same package: FSM state encoding IDLE=0, BUSY=1, DONE=2.
- One sub-module: alu_seq_shift_step.
  - Combinational.
  - Inputs: value, direction/arith mode, step amount (0..SHIFT_STEP).
  - Output: shifted value.
  - Instantiated once by the iterative shifter.

Test Plan:
- Reset: hold reset_n=0 two cycles mid-MUL, then release -> out_valid=0, res=0, cond=0, in_ready=1 next cycle; the aborted MUL never appears.
- ADD a=32'hFFFF_FFFF, b=1, out_ready=1 -> out_valid one cycle after accept, res=0, cond=0. Then LT a=32'h8000_0000, b=1 -> cond=1, res=0. Then LTU with the same operands -> cond=0.
- SRA a=32'h8000_0000, b=32'h0000_0104 (shamt=4), SHIFT_STEP=1 -> out_valid 5 cycles after accept, res=32'hF800_0000. Repeat with SHIFT_STEP=4 -> latency 2, same res.
- SLL with shamt=0 -> latency 1, res=a. MUL a=7, b=32'hFFFF_FFFF -> latency 33, res=32'hFFFF_FFF9.
- Back-to-back with out_ready tied high: ADD, XOR and EQ offered on consecutive cycles -> one result per cycle, no bubbles, in_ready constantly 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> res/cond stable, in_ready=0, new in_valid ignored. Illegal opcode 15 -> illegal=1, res=0, cond=0.
